// File: rtl/lenet_frame_buffer.sv
// LeNet ROI frame buffer: captures each 28x28 grey ROI into one of two banks
// (with optional binarise/invert) and replays completed frames as an indexed
// valid/ready stream, decoupling camera timing from inference timing.
module lenet_frame_buffer #(
   parameter int unsigned IMG_W = 28,
   parameter int unsigned IMG_H = 28,
   parameter int unsigned DW    = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          frame_vsync,
   input  logic          pix_valid,
   input  logic [DW-1:0] pix_data,
   input  logic [7:0]    bin_threshod,
   input  logic          bin_en,
   input  logic          inv_en,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [9:0]    out_index,
   output logic          out_last,
   output logic          frame_done,
   output logic          frame_drop,
   output logic          short_frame
);

   localparam int unsigned N  = IMG_W * IMG_H;
   localparam int unsigned IW = 10;
   localparam int unsigned AW = $clog2(2 * N);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_STREAM
   } rd_state_t;

   // Two banks packed into one RAM: bank b occupies [b*N, b*N+N-1]
   logic [DW-1:0] r_mem [0:2*N-1];
   logic [DW-1:0] r_ram_q;

   // Write side state
   logic          r_vs_d;
   logic          r_wr_active;
   logic          r_wr_bank;
   logic [IW-1:0] r_wr_cnt;
   logic          r_bin;
   logic          r_inv;
   logic          r_done;
   logic          r_drop;
   logic          r_short;

   // Bank bookkeeping: busy = allocated (writing, full or being read),
   // full = complete and waiting for the read side, first = older full bank
   logic [1:0]    r_busy;
   logic [1:0]    r_full;
   logic          r_first;

   // Read side state
   rd_state_t     r_state;
   logic          r_rd_bank;
   logic          r_valid;
   logic [IW-1:0] r_index;
   logic          r_last;

   logic          w_vs_rise;
   logic          w_alloc_ok;
   logic          w_new_bank;
   logic          w_act;
   logic          w_bank;
   logic [IW-1:0] w_cnt;
   logic          w_bin;
   logic          w_inv;
   logic          w_we;
   logic          w_done;
   logic [DW-1:0] w_bin_s;
   logic [DW-1:0] w_wdata;
   logic [AW-1:0] w_wr_addr;
   logic          w_start_rd;
   logic          w_pick_bank;
   logic          w_accept;
   logic          w_re;
   logic [IW-1:0] w_rd_idx;
   logic [AW-1:0] w_rd_addr;
   logic [1:0]    w_alloc_mask;
   logic [1:0]    w_free_mask;
   logic [1:0]    w_full_set;
   logic [1:0]    w_full_clr;

   // Frame-start decision and effective write target for this cycle; a sample
   // coincident with the vsync edge already belongs to the new frame
   always_comb begin
      w_vs_rise  = frame_vsync & ~r_vs_d;
      w_alloc_ok = |(~r_busy);
      w_new_bank = r_busy[0];
      w_act      = r_wr_active;
      w_bank     = r_wr_bank;
      w_cnt      = r_wr_cnt;
      w_bin      = r_bin;
      w_inv      = r_inv;
      if (w_vs_rise) begin
         w_act = r_wr_active | w_alloc_ok;
         w_bank = r_wr_active ? r_wr_bank : w_new_bank;
         w_cnt = '0;
         w_bin = bin_en;
         w_inv = inv_en;
      end
      w_we   = pix_valid & w_act;
      w_done = w_we & (w_cnt == IW'(N - 1));
   end

   // Sample processing: strict-threshold binarise, then optional invert
   always_comb begin
      w_bin_s = pix_data;
      if (w_bin) w_bin_s = (pix_data > bin_threshod) ? '1 : '0;
      w_wdata   = w_inv ? ~w_bin_s : w_bin_s;
      w_wr_addr = (w_bank ? AW'(N) : '0) + AW'(w_cnt);
   end

   // Read-side selection, RAM read enable and bank mask updates
   always_comb begin
      w_start_rd  = (r_state == S_IDLE) & (|r_full);
      w_pick_bank = (r_full == 2'b11) ? r_first : r_full[1];
      w_accept    = (r_state == S_STREAM) & r_valid & out_ready;
      w_re        = (r_state == S_FETCH) | (w_accept & ~r_last);
      w_rd_idx    = (r_state == S_FETCH) ? '0 : r_index + IW'(1);
      w_rd_addr   = (r_rd_bank ? AW'(N) : '0) + AW'(w_rd_idx);
      w_alloc_mask = (w_vs_rise & ~r_wr_active & w_alloc_ok) ? (2'b01 << w_new_bank) : '0;
      w_free_mask  = (w_accept & r_last) ? (2'b01 << r_rd_bank) : '0;
      w_full_set   = w_done ? (2'b01 << w_bank) : '0;
      w_full_clr   = w_start_rd ? (2'b01 << w_pick_bank) : '0;
   end

   // Buffer RAM: one write port, one registered read port with enable
   always_ff @(posedge clk) begin
      if (w_we) r_mem[w_wr_addr] <= w_wdata;
      if (w_re) r_ram_q <= r_mem[w_rd_addr];
   end

   // Write side: frame tracking, sample counter and status pulses
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vs_d      <= 1'b0;
         r_wr_active <= 1'b0;
         r_wr_bank   <= 1'b0;
         r_wr_cnt    <= '0;
         r_bin       <= 1'b0;
         r_inv       <= 1'b0;
         r_done      <= 1'b0;
         r_drop      <= 1'b0;
         r_short     <= 1'b0;
      end else begin
         r_vs_d      <= frame_vsync;
         r_wr_active <= w_act & ~w_done;
         r_wr_bank   <= w_bank;
         r_wr_cnt    <= w_done ? '0 : (w_we ? w_cnt + IW'(1) : w_cnt);
         r_bin       <= w_bin;
         r_inv       <= w_inv;
         r_done      <= w_done;
         r_drop      <= w_vs_rise & ~r_wr_active & ~w_alloc_ok;
         r_short     <= w_vs_rise & r_wr_active & (r_wr_cnt != '0);
      end
   end

   // Bank ownership and replay ordering
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_busy  <= '0;
         r_full  <= '0;
         r_first <= 1'b0;
      end else begin
         r_busy <= (r_busy | w_alloc_mask) & ~w_free_mask;
         r_full <= (r_full | w_full_set) & ~w_full_clr;
         if (w_done && !r_full[~w_bank]) r_first <= w_bank;
      end
   end

   // Read FSM: IDLE -> FETCH (prime RAM) -> STREAM until last beat accepted
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_rd_bank <= 1'b0;
         r_valid   <= 1'b0;
         r_index   <= '0;
         r_last    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_valid <= 1'b0;
               if (w_start_rd) begin
                  r_rd_bank <= w_pick_bank;
                  r_state   <= S_FETCH;
               end
            end
            S_FETCH: begin
               r_valid <= 1'b1;
               r_index <= '0;
               r_last  <= (N == 1);
               r_state <= S_STREAM;
            end
            S_STREAM: begin
               if (w_accept) begin
                  if (r_last) begin
                     r_valid <= 1'b0;
                     r_last  <= 1'b0;
                     r_index <= '0;
                     r_state <= S_IDLE;
                  end else begin
                     r_index <= w_rd_idx;
                     r_last  <= (w_rd_idx == IW'(N - 1));
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign out_valid   = r_valid;
   assign out_data    = r_valid ? r_ram_q : '0;
   assign out_index   = r_index;
   assign out_last    = r_last;
   assign frame_done  = r_done;
   assign frame_drop  = r_drop;
   assign short_frame = r_short;

endmodule
